pipelined_mult_nxn: RTL and testbench
=====================================

PIPELINED_MULT_NXN -- requirements
Module: pipelined_mult_nxn

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 2: total register stages from operand capture to out_p; legal range 2..WIDTH+1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands on in_a/in_b/in_tc are valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 in_tc  input  1  1 = two's-complement operands and product; 0 = unsigned.
REQ-010 out_valid  output  1  out_p holds a completed product.
REQ-011 out_ready  input  1  consumer accepts out_p this cycle.
REQ-012 out_p  output  2*WIDTH  product.

Function
REQ-013 Transfer on the input side occurs when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-014 Pipeline advance condition adv = !out_valid || out_ready; all stage registers and their valid bits update only when adv=1.
REQ-015 in_ready = adv, combinational, with no dependence on in_valid.
REQ-016 Stage 1 registers in_a, in_b, in_tc and valid=in_valid.
REQ-017 Stages 2..STAGES each add R = ceil(WIDTH/(STAGES-1)) partial-product rows to a 2*WIDTH-bit running sum; the final stage output is out_p/out_valid.
REQ-018 Without stalls, a product accepted at edge n appears on out_p with out_valid=1 after edge n+STAGES-1, i.e. the latency is STAGES cycles counted from the accepting edge inclusive.
REQ-019 out_p = in_a*in_b exactly, computed modulo 2^(2*WIDTH); for in_tc=1, operands and result are two's complement, with no overflow possible.
REQ-020 in_tc is carried per transaction; mixed-mode back-to-back operands each produce a correct result.
REQ-021 Bubbles (valid=0 stages) are not collapsed, and the throughput is one product per cycle when out_ready=1.
REQ-022 When stalled (out_valid=1, out_ready=0), out_p and every stage register hold their values, and no operand is accepted.
REQ-023 When out_valid=0, out_p holds its last value; consumers ignore it.
REQ-024 Transactions are never dropped, duplicated, or reordered.
REQ-025 Illegal WIDTH/STAGES values stop elaboration with an error.

Reset
REQ-026 rst=1 clears all stage valid bits, operand registers, running sums, and out_p to 0 immediately, independent of clk.
REQ-027 Reset mid-operation discards all in-flight transactions; after rst deasserts, out_valid=0 until a new transaction completes.
REQ-028 in_ready=1 while rst=1.

Structure
REQ-029 Shared package mult_pkg holds the WIDTH/STAGES limits, the row-per-stage function ceil_div, and the default parameter values.
REQ-030 Each accumulation stage is one instance of sub-module mult_pp_stage (ports: row base index, operands, tc, sum in/out, valid in/out, adv); the top level generates STAGES-1 instances.
REQ-031 Signed handling uses Baugh-Wooley or sign-extended rows inside mult_pp_stage; there is no separate post-correction stage.

Verification
REQ-032 WIDTH=8, STAGES=2, in_tc=0: a=8'hFF, b=8'hFF -> out_p=16'hFE01 with out_valid 2 cycles after acceptance.
REQ-033 WIDTH=8, in_tc=1: a=8'h80, b=8'h80 -> 16'h4000; a=8'hFF, b=8'hFF -> 16'h0001; a=8'h80, b=8'h7F -> 16'hC080.
REQ-034 WIDTH=8, STAGES=5: stream 20 random mixed-tc operand sets with out_ready=1 -> 20 correct in-order results, one per cycle, first at latency 5.
REQ-035 Hold out_ready=0 for 4 cycles with the pipe full -> in_ready=0, out_p stable, no loss; after release, all results are delivered in order.
REQ-036 Assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 and out_p=0 immediately; the next accepted a=3, b=5 yields out_p=15.
REQ-037 WIDTH=16, STAGES=17: a=16'hFFFF, b=16'h0002 with in_tc=1 -> 32'hFFFFFFFE; with in_tc=0 -> 32'h0001FFFE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared limits, defaults and helpers for the pipelined N x N multiplier.
package mult_pkg;

    localparam int unsigned WidthMin      = 2;
    localparam int unsigned WidthMax      = 32;
    localparam int unsigned StagesMin     = 2;
    localparam int unsigned DefaultWidth  = 8;
    localparam int unsigned DefaultStages = 2;
    // Wide enough for any row base index reachable with WidthMax.
    localparam int unsigned RowBaseW      = 7;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/mult_pp_stage.sv
// One accumulation stage: adds ROWS partial-product rows starting at row_base_i to the running sum.
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned ROWS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv_i,
    input  logic [RowBaseW-1:0]   row_base_i,
    input  logic [WIDTH-1:0]      a_i,
    input  logic [WIDTH-1:0]      b_i,
    input  logic                  tc_i,
    input  logic [2*WIDTH-1:0]    sum_i,
    input  logic                  valid_i,
    output logic [WIDTH-1:0]      a_o,
    output logic [WIDTH-1:0]      b_o,
    output logic                  tc_o,
    output logic [2*WIDTH-1:0]    sum_o,
    output logic                  valid_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_q, b_q;
    logic             tc_q, valid_q;
    logic [PW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    a_ext, row;
    logic [WIDTH-1:0] b_sh;
    int unsigned      idx;

    // Sign-extended rows; in signed mode the multiplier MSB carries negative weight.
    always_comb begin
        a_ext = {{WIDTH{tc_i & a_i[WIDTH-1]}}, a_i};
        sum_d = sum_i;
        idx   = 0;
        b_sh  = '0;
        row   = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            idx  = 32'(row_base_i) + r;
            b_sh = b_i >> idx;
            row  = a_ext << idx;
            if (idx < WIDTH && b_sh[0]) begin
                if (tc_i && idx == WIDTH - 1) begin
                    sum_d = sum_d - row;
                end else begin
                    sum_d = sum_d + row;
                end
            end
        end
    end

    // Data only loads with a valid transaction so bubbles leave the held result untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            tc_q    <= 1'b0;
            sum_q   <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                tc_q  <= tc_i;
                sum_q <= sum_d;
            end
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign tc_o    = tc_q;
    assign sum_o   = sum_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_mult_nxn.sv
// Pipelined N x N multiplier, signed or unsigned per transaction, with valid/ready handshake.
module pipelined_mult_nxn
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STAGES = DefaultStages
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    input  logic                 in_tc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_p_o
);

    localparam int unsigned NumAcc = (STAGES < 2) ? 1 : STAGES - 1;
    localparam int unsigned Rows   = ceil_div(WIDTH, NumAcc);

    if (WIDTH < WidthMin || WIDTH > WidthMax || STAGES < StagesMin || STAGES > WIDTH + 1)
    begin : g_bad_params
        $error("pipelined_mult_nxn: illegal WIDTH/STAGES combination");
    end

    logic adv;

    logic [WIDTH-1:0]   cap_a_q, cap_b_q;
    logic               cap_tc_q, cap_v_q;

    logic [WIDTH-1:0]   a_s   [NumAcc+1];
    logic [WIDTH-1:0]   b_s   [NumAcc+1];
    logic               tc_s  [NumAcc+1];
    logic               v_s   [NumAcc+1];
    logic [2*WIDTH-1:0] sum_s [NumAcc+1];
    logic               unused_tail;

    assign adv = !out_valid_o || out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_v_q  <= 1'b0;
            cap_a_q  <= '0;
            cap_b_q  <= '0;
            cap_tc_q <= 1'b0;
        end else if (adv) begin
            cap_v_q <= in_valid_i;
            if (in_valid_i) begin
                cap_a_q  <= in_a_i;
                cap_b_q  <= in_b_i;
                cap_tc_q <= in_tc_i;
            end
        end
    end

    assign a_s[0]   = cap_a_q;
    assign b_s[0]   = cap_b_q;
    assign tc_s[0]  = cap_tc_q;
    assign v_s[0]   = cap_v_q;
    assign sum_s[0] = '0;

    for (genvar k = 0; k < NumAcc; k++) begin : g_stage
        mult_pp_stage #(
            .WIDTH (WIDTH),
            .ROWS  (Rows)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv_i      (adv),
            .row_base_i (RowBaseW'(k * Rows)),
            .a_i        (a_s[k]),
            .b_i        (b_s[k]),
            .tc_i       (tc_s[k]),
            .sum_i      (sum_s[k]),
            .valid_i    (v_s[k]),
            .a_o        (a_s[k+1]),
            .b_o        (b_s[k+1]),
            .tc_o       (tc_s[k+1]),
            .sum_o      (sum_s[k+1]),
            .valid_o    (v_s[k+1])
        );
    end

    // Operands forwarded out of the last stage have no consumer.
    assign unused_tail = ^{a_s[NumAcc], b_s[NumAcc], tc_s[NumAcc]};

    assign in_ready_o  = adv;
    assign out_valid_o = v_s[NumAcc];
    assign out_p_o     = sum_s[NumAcc];

endmodule

// File: tb/tb_pipelined_mult_nxn.sv
// Bench for pipelined_mult_nxn: scoreboarded 8x8/5-stage instance plus directed 8x8/2 and 16x16/17.
module tb_pipelined_mult_nxn;

    localparam int unsigned S = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_tc, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_p;

    logic        v2, rdy2, tc2, ov2, ordy2;
    logic [7:0]  a2, b2;
    logic [15:0] p2;

    logic        v3, rdy3, tc3, ov3, ordy3;
    logic [15:0] a3, b3;
    logic [31:0] p3;

    pipelined_mult_nxn #(.WIDTH(8), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a),
        .in_b_i(in_b), .in_tc_i(in_tc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_p_o(out_p)
    );

    pipelined_mult_nxn #(.WIDTH(8), .STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid_i(v2), .in_ready_o(rdy2), .in_a_i(a2), .in_b_i(b2),
        .in_tc_i(tc2), .out_valid_o(ov2), .out_ready_i(ordy2), .out_p_o(p2)
    );

    pipelined_mult_nxn #(.WIDTH(16), .STAGES(17)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid_i(v3), .in_ready_o(rdy3), .in_a_i(a3), .in_b_i(b3),
        .in_tc_i(tc3), .out_valid_o(ov3), .out_ready_i(ordy3), .out_p_o(p3)
    );

    typedef struct {
        logic [15:0] p;
        int unsigned cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic tc);
        logic signed [15:0] sa, sbv;
        if (tc) begin
            sa  = {{8{a[7]}}, a};
            sbv = {{8{b[7]}}, b};
            return sa * sbv;
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    // Output side of the scoreboard: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("product", out_p, e.p);
                if (e.lat) check("latency", 64'(cyc - e.cyc), S);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic tc,
                        input logic [15:0] exp);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tc    = tc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 64'(in_ready), 1);
        if (in_ready) sb.push_back('{exp, cyc, chk_lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra, rb;
        logic        rtc;
        logic [15:0] last_p, held;
        int          n;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_tc = 1'b0; out_ready = 1'b1;
        v2 = 1'b0; a2 = '0; b2 = '0; tc2 = 1'b0; ordy2 = 1'b1;
        v3 = 1'b0; a3 = '0; b3 = '0; tc3 = 1'b0; ordy3 = 1'b1;
        last_p = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner products, back to back
        chk_lat = 1'b1;
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        send(8'h80, 8'h80, 1'b1, 16'h4000);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001);
        send(8'h80, 8'h7F, 1'b1, 16'hC080);
        wait_drain();

        // Random mixed-mode stream, one per cycle
        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rtc = 1'($urandom_range(0, 1));
            last_p = ref8(ra, rb, rtc);
            send(ra, rb, rtc, last_p);
        end
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_hold", out_p, last_p);

        // Backpressure with a full pipe
        chk_lat = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rtc = 1'($urandom_range(0, 1));
            send(ra, rb, rtc, ref8(ra, rb, rtc));
        end
        check("stall_pre_valid", out_valid, 1);
        held      = out_p;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        in_tc     = 1'b0;
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_p", out_p, held);
        end
        out_ready = 1'b1;
        send(8'h12, 8'h34, 1'b0, 16'h03A8);
        wait_drain();

        // Reset with three transactions in flight
        send(8'd9, 8'd9, 1'b0, 16'd81);
        wait_drain();
        send(8'd1, 8'd2, 1'b0, 16'd2);
        send(8'd3, 8'd4, 1'b0, 16'd12);
        send(8'd5, 8'd6, 1'b0, 16'd30);
        check("pre_rst_out_p", out_p, 16'd81);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_p", out_p, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_out_valid", out_valid, 0);
        end
        chk_lat = 1'b1;
        send(8'd3, 8'd5, 1'b0, 16'd15);
        wait_drain();

        // WIDTH=8, STAGES=2 directed
        v2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF; tc2 = 1'b0;
        #1;
        check("d2_in_ready", rdy2, 1);
        @(posedge clk);
        #1;
        v2 = 1'b0;
        check("d2_valid_early", ov2, 0);
        @(posedge clk);
        #1;
        check("d2_valid", ov2, 1);
        check("d2_unsigned", p2, 16'hFE01);
        v2 = 1'b1; a2 = 8'hFF; b2 = 8'hFF; tc2 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        check("d2_bubble", ov2, 0);
        @(posedge clk);
        #1;
        check("d2_valid_tc", ov2, 1);
        check("d2_signed", p2, 16'h0001);
        @(posedge clk);
        #1;
        check("d2_valid_drop", ov2, 0);
        check("d2_hold", p2, 16'h0001);

        // WIDTH=16, STAGES=17 directed, signed then unsigned
        for (int m = 0; m < 2; m++) begin
            v3 = 1'b1; a3 = 16'hFFFF; b3 = 16'h0002; tc3 = (m == 0);
            @(posedge clk);
            #1;
            v3 = 1'b0;
            n = 1;
            while (!ov3 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("d3_valid", ov3, 1);
            check("d3_latency", 64'(n), 17);
            check(m == 0 ? "d3_signed" : "d3_unsigned", p3,
                  m == 0 ? 32'hFFFF_FFFE : 32'h0001_FFFE);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
